// File: rtl/pcie_tl_pkg.sv
// Shared definitions for the parametrised transaction layer: FSM state codes,
// width helpers and destination-field extraction.
package pcie_tl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } tl_state_t;

    function automatic int ch_width(input int channels);
        return $clog2(channels);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Destination channel lives in the top ch_w bits of a data_w-bit word.
    function automatic int dest_field(input logic [63:0] word, input int data_w, input int ch_w);
        return int'((word >> (data_w - ch_w)) & ((64'd1 << ch_w) - 64'd1));
    endfunction

endpackage

// File: rtl/pcie_tl_fifo.sv
// Show-ahead FIFO with synchronous flush, full/empty status and registered
// almost-full / almost-empty flags against externally latched thresholds.
module pcie_tl_fifo
    import pcie_tl_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH = 8,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    input  logic [PTR_W-1:0]  umbral_alto,
    input  logic [PTR_W-1:0]  umbral_bajo,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              drop
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    occ, occ_next;
    logic              do_push, do_pop;

    assign full    = (occ == (PTR_W+1)'(DEPTH));
    assign empty   = (occ == '0);
    assign do_pop  = pop && !empty;
    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !pop;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_comb begin
        occ_next = occ;
        if (do_push && !do_pop)
            occ_next = occ + 1'b1;
        else if (!do_push && do_pop)
            occ_next = occ - 1'b1;
        if (flush)
            occ_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            occ          <= occ_next;
            almost_full  <= (occ_next >= {1'b0, umbral_alto});
            almost_empty <= (occ_next <= {1'b0, umbral_bajo});
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pcie_tl_param.sv
// Parametrised transaction layer: input FIFOs -> round-robin router -> output FIFOs,
// pop counters with req/idx readback, control FSM. Build option: PCIE_TL_OVF_ERROR_EN.
module pcie_tl_param
    import pcie_tl_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DATA_W = 10,
    parameter int DEPTH = 8,
    parameter int CNT_W = 5,
    localparam int CH_W = ch_width(CHANNELS),
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic [PTR_W-1:0]           umbral_alto,
    input  logic [PTR_W-1:0]           umbral_bajo,
    input  logic [CHANNELS-1:0]        push_in,
    input  logic [CHANNELS*DATA_W-1:0] data_in,
    input  logic [CHANNELS-1:0]        pop_out,
    output logic [CHANNELS*DATA_W-1:0] data_out,
    output logic [CHANNELS-1:0]        almost_full,
    output logic [CHANNELS-1:0]        almost_empty,
    output logic [CHANNELS-1:0]        empty_out,
    input  logic                       req,
    input  logic [CH_W-1:0]            idx,
    output logic [CNT_W-1:0]           contador,
    output logic                       valid,
    output logic [2:0]                 state,
    output logic                       overflow
);

    tl_state_t           st, st_next;
    logic                run, pop_en, flush, ovf_event, any_busy, grant_valid;
    logic [PTR_W-1:0]    alto_q, bajo_q;
    logic [CH_W-1:0]     rr_ptr, grant;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CHANNELS-1:0] in_push, in_pop, in_full, in_empty, in_drop, cand;
    logic [CHANNELS-1:0] in_af_unused, in_ae_unused, in_full_unused, out_drop_unused;
    logic [CHANNELS-1:0] out_push, out_pop, out_full, out_empty;
    logic [DATA_W-1:0]   in_dout [CHANNELS];
    logic [DATA_W-1:0]   out_din [CHANNELS];
    logic [DATA_W-1:0]   out_dout [CHANNELS];
    logic [CH_W-1:0]     dest [CHANNELS];

    assign run       = (st == ST_IDLE) || (st == ST_ACTIVE);
    assign pop_en    = (st != ST_RESET) && (st != ST_INIT);
    assign flush     = (st == ST_INIT);
    assign ovf_event = |in_drop;
    assign any_busy  = ~&{in_empty, out_empty};
    assign empty_out = out_empty;
    assign state     = st;
    assign in_full_unused = in_full;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign in_push[i] = push_in[i] & run;
        assign out_pop[i] = pop_out[i] & pop_en;
        assign dest[i]    = CH_W'(dest_field(64'(in_dout[i]), DATA_W, CH_W));
        assign cand[i]    = run & ~in_empty[i] & ~out_full[dest[i]] & ~almost_full[dest[i]];
        assign data_out[i*DATA_W +: DATA_W] = out_dout[i];

        pcie_tl_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in (
            .clk(clk), .rst_n(reset), .flush(flush),
            .push(in_push[i]), .pop(in_pop[i]), .din(data_in[i*DATA_W +: DATA_W]),
            .umbral_alto(alto_q), .umbral_bajo(bajo_q),
            .dout(in_dout[i]), .full(in_full[i]), .empty(in_empty[i]),
            .almost_full(in_af_unused[i]), .almost_empty(in_ae_unused[i]), .drop(in_drop[i])
        );

        pcie_tl_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out (
            .clk(clk), .rst_n(reset), .flush(flush),
            .push(out_push[i]), .pop(out_pop[i]), .din(out_din[i]),
            .umbral_alto(alto_q), .umbral_bajo(bajo_q),
            .dout(out_dout[i]), .full(out_full[i]), .empty(out_empty[i]),
            .almost_full(almost_full[i]), .almost_empty(almost_empty[i]), .drop(out_drop_unused[i])
        );
    end

    // First candidate at or after rr_ptr wins; index arithmetic wraps at CH_W bits.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        in_pop      = '0;
        out_push    = '0;
        for (int o = 0; o < CHANNELS; o++) out_din[o] = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!grant_valid && cand[rr_ptr + CH_W'(k)]) begin
                grant_valid = 1'b1;
                grant       = rr_ptr + CH_W'(k);
            end
        end
        if (grant_valid) begin
            in_pop[grant]         = 1'b1;
            out_push[dest[grant]] = 1'b1;
            out_din[dest[grant]]  = in_dout[grant];
        end
    end

    always_comb begin
        st_next = st;
        unique case (st)
            ST_RESET: st_next = ST_INIT;
            ST_INIT:  if (!init) st_next = ST_IDLE;
            ST_IDLE, ST_ACTIVE: begin
                if (init)
                    st_next = ST_INIT;
`ifdef PCIE_TL_OVF_ERROR_EN
                else if (ovf_event)
                    st_next = ST_ERROR;
`endif
                else if (any_busy)
                    st_next = ST_ACTIVE;
                else
                    st_next = ST_IDLE;
            end
            ST_ERROR: if (init) st_next = ST_INIT;
            default:  st_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= ST_RESET;
            alto_q   <= '1;
            bajo_q   <= '0;
            rr_ptr   <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            contador <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else begin
            st       <= st_next;
            valid    <= req;
            contador <= req ? cnt[idx] : '0;
            if (st == ST_INIT) begin
                alto_q   <= umbral_alto;
                bajo_q   <= umbral_bajo;
                rr_ptr   <= '0;
                overflow <= 1'b0;
                for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
            end else begin
                if (grant_valid) rr_ptr <= grant + 1'b1;
                if (ovf_event) overflow <= 1'b1;
                for (int i = 0; i < CHANNELS; i++)
                    if (out_pop[i] && !out_empty[i]) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcie_tl_param.sv
// Self-checking bench for pcie_tl_param: queue-based reference model, directed
// scenarios followed by a randomized phase and an asynchronous mid-stream reset.
module tb_pcie_tl_param;
    import pcie_tl_pkg::*;

    localparam int CH = 4, DW = 10, DEPTH = 8, CNT_W = 5, CH_W = 2, PTR_W = 3;
    localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;
`ifdef PCIE_TL_OVF_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, init, req;
    logic [PTR_W-1:0]  umbral_alto, umbral_bajo;
    logic [CH-1:0]     push_in, pop_out;
    logic [CH*DW-1:0]  data_in, data_out;
    logic [CH-1:0]     almost_full, almost_empty, empty_out;
    logic [CH_W-1:0]   idx;
    logic [CNT_W-1:0]  contador;
    logic              valid, overflow;
    logic [2:0]        state;

    int n_tests = 0, n_fail = 0;

    logic [DW-1:0] inq [CH][$];
    logic [DW-1:0] outq [CH][$];
    int m_cnt [CH];
    bit m_af [CH];
    bit m_ae [CH];
    int m_rr, m_state, m_hi, m_lo, m_cont;
    bit m_ovf, m_valid;

    pcie_tl_param #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .init(init), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .push_in(push_in), .data_in(data_in), .pop_out(pop_out), .data_out(data_out),
        .almost_full(almost_full), .almost_empty(almost_empty), .empty_out(empty_out),
        .req(req), .idx(idx), .contador(contador), .valid(valid), .state(state), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            inq[i].delete();
            outq[i].delete();
            m_cnt[i] = 0;
            m_af[i] = 1'b0;
            m_ae[i] = 1'b1;
        end
        m_rr = 0; m_state = S_RESET; m_ovf = 1'b0;
        m_hi = DEPTH - 1; m_lo = 0; m_valid = 1'b0; m_cont = 0;
    endtask

    // One rising edge of the reference model, using the inputs held across it.
    task automatic model_edge();
        int s, grant, gd, d;
        bit run, pop_en, any_ne, ovf_ev;
        bit full_pre [CH];
        logic [DW-1:0] w;
        s = m_state;
        run = (s == S_IDLE) || (s == S_ACTIVE);
        pop_en = (s != S_RESET) && (s != S_INIT);
        grant = -1; gd = 0; any_ne = 1'b0; ovf_ev = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (inq[i].size() > 0 || outq[i].size() > 0) any_ne = 1'b1;
            full_pre[i] = (inq[i].size() == DEPTH);
        end
        if (run) begin
            for (int k = 0; k < CH; k++) begin
                int j;
                j = (m_rr + k) % CH;
                if (grant < 0 && inq[j].size() > 0) begin
                    w = inq[j][0];
                    d = int'(w >> (DW - CH_W));
                    if (!m_af[d] && outq[d].size() < DEPTH) begin
                        grant = j; gd = d;
                    end
                end
            end
        end
        m_valid = req;
        m_cont = req ? m_cnt[idx] : 0;
        for (int i = 0; i < CH; i++)
            if (pop_out[i] && pop_en && outq[i].size() > 0) begin
                void'(outq[i].pop_front());
                m_cnt[i] = (m_cnt[i] + 1) % (1 << CNT_W);
            end
        if (grant >= 0) begin
            w = inq[grant].pop_front();
            outq[gd].push_back(w);
            m_rr = (grant + 1) % CH;
        end
        for (int i = 0; i < CH; i++)
            if (run && push_in[i]) begin
                if (!full_pre[i] || grant == i) inq[i].push_back(data_in[i*DW +: DW]);
                else ovf_ev = 1'b1;
            end
        if (s == S_INIT)
            for (int i = 0; i < CH; i++) begin
                inq[i].delete(); outq[i].delete(); m_cnt[i] = 0;
            end
        for (int i = 0; i < CH; i++) begin
            m_af[i] = (outq[i].size() >= m_hi);
            m_ae[i] = (outq[i].size() <= m_lo);
        end
        if (s == S_INIT) begin
            m_hi = int'(umbral_alto); m_lo = int'(umbral_bajo); m_rr = 0; m_ovf = 1'b0;
        end else if (ovf_ev) m_ovf = 1'b1;
        case (s)
            S_RESET: m_state = S_INIT;
            S_INIT:  m_state = init ? S_INIT : S_IDLE;
            S_IDLE, S_ACTIVE: begin
                if (init) m_state = S_INIT;
                else if (ERR_EN && ovf_ev) m_state = S_ERROR;
                else m_state = any_ne ? S_ACTIVE : S_IDLE;
            end
            default: m_state = init ? S_INIT : S_ERROR;
        endcase
    endtask

    task automatic check(input string tag);
        logic [CH*DW-1:0] e_data;
        logic [CH-1:0] e_af, e_ae, e_em;
        for (int i = 0; i < CH; i++) begin
            e_data[i*DW +: DW] = (outq[i].size() > 0) ? outq[i][0] : '0;
            e_af[i] = m_af[i];
            e_ae[i] = m_ae[i];
            e_em[i] = (outq[i].size() == 0);
        end
        n_tests++;
        assert (data_out === e_data) else begin
            n_fail++; $error("FAIL %s data_out got=%h exp=%h", tag, data_out, e_data); end
        n_tests++;
        assert (almost_full === e_af) else begin
            n_fail++; $error("FAIL %s almost_full got=%b exp=%b", tag, almost_full, e_af); end
        n_tests++;
        assert (almost_empty === e_ae) else begin
            n_fail++; $error("FAIL %s almost_empty got=%b exp=%b", tag, almost_empty, e_ae); end
        n_tests++;
        assert (empty_out === e_em) else begin
            n_fail++; $error("FAIL %s empty_out got=%b exp=%b", tag, empty_out, e_em); end
        n_tests++;
        assert (contador === CNT_W'(m_cont)) else begin
            n_fail++; $error("FAIL %s contador got=%0d exp=%0d", tag, contador, m_cont); end
        n_tests++;
        assert (valid === m_valid) else begin
            n_fail++; $error("FAIL %s valid got=%b exp=%b", tag, valid, m_valid); end
        n_tests++;
        assert (state === 3'(m_state)) else begin
            n_fail++; $error("FAIL %s state got=%0d exp=%0d", tag, state, m_state); end
        n_tests++;
        assert (overflow === m_ovf) else begin
            n_fail++; $error("FAIL %s overflow got=%b exp=%b", tag, overflow, m_ovf); end
    endtask

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp); end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check(tag);
    endtask

    task automatic quiet();
        push_in = '0; pop_out = '0; req = 1'b0; init = 1'b0;
    endtask

    task automatic drive_word(input int ch, input logic [DW-1:0] w);
        push_in[ch] = 1'b1;
        data_in[ch*DW +: DW] = w;
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; req = 1'b0; idx = '0;
        push_in = '0; pop_out = '0; data_in = '0;
        umbral_alto = 3'd6; umbral_bajo = 3'd1;
        model_reset();
        #2 reset = 1'b0;
        #2 check("reset_values");
        @(negedge clk);
        check("reset_hold");
        reset = 1'b1;
        step("to_init");
        expect_eq("state_init", 32'(state), S_INIT);
        init = 1'b1;
        step("init_hold");
        init = 1'b0;
        step("to_idle");
        expect_eq("state_idle", 32'(state), S_IDLE);
        expect_eq("empty_all", 32'(empty_out), 32'hF);

        // single word to destination 3
        drive_word(0, 10'h3A5);
        step("push_3a5");
        quiet();
        step("xfer_3a5");
        expect_eq("dout3_3a5", 32'(data_out[3*DW +: DW]), 32'h3A5);
        expect_eq("state_active", 32'(state), S_ACTIVE);
        pop_out[3] = 1'b1;
        step("pop3");
        quiet();
        step("back_idle");
        expect_eq("state_back_idle", 32'(state), S_IDLE);
        req = 1'b1; idx = 2'd3;
        step("read_cnt3");
        expect_eq("cnt3", 32'(contador), 32'd1);
        expect_eq("cnt3_valid", 32'(valid), 32'd1);
        quiet();
        init = 1'b1;
        step("reinit_a");
        init = 1'b0;
        step("reinit_b");

        // round-robin: four simultaneous words to destination 1
        for (int i = 0; i < CH; i++) drive_word(i, DW'(10'h1A0 + i));
        step("rr_push");
        quiet();
        for (int i = 0; i < CH; i++) step("rr_xfer");
        for (int i = 0; i < CH; i++) begin
            expect_eq("rr_order", 32'(data_out[1*DW +: DW]), 32'(10'h1A0 + i));
            pop_out[1] = 1'b1;
            step("rr_pop");
            quiet();
        end

        // backpressure on destination 2
        for (int k = 0; k < 6; k++) begin
            drive_word(0, DW'(10'h200 + k));
            step("fill2");
        end
        quiet();
        step("fill2_settle"); step("fill2_settle");
        expect_eq("af2_set", 32'(almost_full[2]), 32'd1);
        drive_word(0, 10'h2EE);
        drive_word(3, 10'h055);
        step("stall_push");
        quiet();
        step("stall_a"); step("stall_b");
        expect_eq("bypass_out0", 32'(empty_out[0]), 32'd0);
        pop_out[2] = 1'b1;
        step("pop2");
        quiet();
        step("resume_a"); step("resume_b");
        expect_eq("af2_again", 32'(almost_full[2]), 32'd1);

        // overflow of input channel 1 while destination 2 is blocked
        for (int k = 0; k < 9; k++) begin
            drive_word(1, DW'(10'h280 + k));
            step("ovf_push");
        end
        quiet();
        expect_eq("ovf_flag", 32'(overflow), 32'd1);
        expect_eq("ovf_state", 32'(state), ERR_EN ? S_ERROR : S_ACTIVE);
        init = 1'b1;
        step("ovf_init");
        init = 1'b0;
        step("ovf_idle");
        expect_eq("ovf_cleared", 32'(overflow), 32'd0);

        // 33 pops on output 0 wrap a 5-bit counter to 1
        for (int k = 0; k < 33; k++) begin
            drive_word(0, DW'($urandom_range(0, 255)));
            pop_out[0] = 1'b1;
            step("stream0");
        end
        push_in = '0;
        for (int k = 0; k < 3; k++) step("drain0");
        quiet();
        req = 1'b1; idx = 2'd0;
        step("read_cnt0");
        expect_eq("cnt0_wrap", 32'(contador), 32'd1);
        expect_eq("cnt0_valid", 32'(valid), 32'd1);
        quiet();
        step("req_low");

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            push_in = 4'($urandom) & 4'($urandom) & 4'($urandom);
            for (int i = 0; i < CH; i++) data_in[i*DW +: DW] = DW'($urandom);
            pop_out = 4'($urandom);
            req = 1'($urandom);
            idx = 2'($urandom);
            init = ($urandom_range(0, 99) == 0);
            if (init) begin
                umbral_alto = 3'($urandom_range(2, 7));
                umbral_bajo = 3'($urandom_range(0, 3));
            end
            step("rand");
        end

        // asynchronous reset in the middle of traffic
        #2 reset = 1'b0;
        #1 model_reset();
        check("async_reset");
        expect_eq("async_state", 32'(state), S_RESET);
        quiet();
        @(negedge clk);
        reset = 1'b1;
        step("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
